// File: rtl/wb_stage_if.sv
// EX/memory-side handshake bundle for the writeback stage.
interface wb_stage_if;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [1:0]  ex_ld_size;
  logic        ex_ld_signed;
  logic [1:0]  ex_ld_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;

  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_size, ex_ld_signed,
           ex_ld_off, mem_rvalid, mem_rdata,
    input  stall
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_size, ex_ld_signed,
           ex_ld_off, mem_rvalid, mem_rdata,
    output stall
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers EX results and load data, drives the register
// file write port, the read-after-write bypass and the load stall.
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned IO_REG       = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_stage_if.slave     bus,
  input  logic [4:0]    readaddr1,
  input  logic [4:0]    readaddr2,
  output logic          we,
  output logic [4:0]    writeaddr,
  output logic [31:0]   writedata,
  output logic          fwd1,
  output logic          fwd2,
  output logic [31:0]   fwd_data,
  output logic          load_err,
  output logic [31:0]   retired
);

  localparam int unsigned CNT_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_WB   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              stall_q, stall_d;
  logic              we_q, we_d;
  logic [4:0]        writeaddr_q, writeaddr_d;
  logic [31:0]       writedata_q, writedata_d;
  logic              load_err_q, load_err_d;
  logic [31:0]       retired_q, retired_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_signed_q, ld_signed_d;
  logic [1:0]        ld_off_q, ld_off_d;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // Field extraction and extension of the returned load word.
  always_comb begin
    ld_byte = bus.mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half = bus.mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    case (ld_size_q)
      2'd0:    ld_data = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{ld_signed_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  // Next-state, write-port and bookkeeping logic.
  always_comb begin
    state_d     = state_q;
    stall_d     = 1'b0;
    we_d        = 1'b0;
    writeaddr_d = writeaddr_q;
    writedata_d = writedata_q;
    load_err_d  = load_err_q;
    retired_d   = retired_q;
    cnt_d       = '0;
    cnt_inc     = cnt_q + CNT_W'(1);
    ld_rd_d     = ld_rd_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    ld_off_d    = ld_off_q;

    case (state_q)
      // LOAD_WB drops stall, so EX may hand over a new op in that cycle;
      // it is accepted exactly as in IDLE to avoid losing it.
      IDLE, LOAD_WB: begin
        state_d = IDLE;
        if (bus.ex_valid) begin
          if (bus.ex_is_load) begin
            ld_rd_d     = bus.ex_rd;
            ld_size_d   = bus.ex_ld_size;
            ld_signed_d = bus.ex_ld_signed;
            ld_off_d    = bus.ex_ld_off;
            state_d     = LOAD_WAIT;
            stall_d     = 1'b1;
          end else begin
            we_d        = (bus.ex_rd != 5'd0);
            writeaddr_d = bus.ex_rd;
            writedata_d = bus.ex_result;
            retired_d   = retired_q + 32'd1;
          end
        end
      end
      LOAD_WAIT: begin
        if (bus.mem_rvalid) begin
          we_d        = (ld_rd_q != 5'd0);
          writeaddr_d = ld_rd_q;
          writedata_d = ld_data;
          retired_d   = retired_q + 32'd1;
          state_d     = LOAD_WB;
        end else if (cnt_inc == CNT_W'(LOAD_TIMEOUT)) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d   = cnt_inc;
          stall_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_q     <= 1'b0;
      we_q        <= 1'b0;
      writeaddr_q <= '0;
      writedata_q <= '0;
      load_err_q  <= 1'b0;
      retired_q   <= '0;
      cnt_q       <= '0;
      ld_rd_q     <= '0;
      ld_size_q   <= '0;
      ld_signed_q <= 1'b0;
      ld_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      we_q        <= we_d;
      writeaddr_q <= writeaddr_d;
      writedata_q <= writedata_d;
      load_err_q  <= load_err_d;
      retired_q   <= retired_d;
      cnt_q       <= cnt_d;
      ld_rd_q     <= ld_rd_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      ld_off_q    <= ld_off_d;
    end
  end

  // Output drive and bypass compare; r0 and the IO register never bypass.
  always_comb begin
    bus.stall = stall_q;
    we        = we_q;
    writeaddr = writeaddr_q;
    writedata = writedata_q;
    fwd_data  = writedata_q;
    load_err  = load_err_q;
    retired   = retired_q;
    fwd1 = we_q && (writeaddr_q == readaddr1) && (readaddr1 != 5'd0) &&
           (readaddr1 != 5'(IO_REG));
    fwd2 = we_q && (writeaddr_q == readaddr2) && (readaddr2 != 5'd0) &&
           (readaddr2 != 5'(IO_REG));
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  logic        clk;
  logic        rst_n;
  logic [4:0]  readaddr1, readaddr2;
  logic        we, fwd1, fwd2, load_err;
  logic [4:0]  writeaddr;
  logic [31:0] writedata, fwd_data, retired;
  int unsigned errors = 0;
  int unsigned checks = 0;

  wb_stage_if bus();

  wb_stage #(.LOAD_TIMEOUT(16), .IO_REG(30)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .readaddr1(readaddr1), .readaddr2(readaddr2),
    .we(we), .writeaddr(writeaddr), .writedata(writedata),
    .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data),
    .load_err(load_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b0;
    bus.ex_rd = rd; bus.ex_result = res;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [1:0] sz, input logic sgn, input logic [1:0] off);
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1;
    bus.ex_rd = rd; bus.ex_ld_size = sz; bus.ex_ld_signed = sgn; bus.ex_ld_off = off;
    bus.ex_result = 32'h5555_5555;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_rd = '0; bus.ex_result = '0; bus.ex_is_load = 1'b0;
    bus.ex_ld_size = '0; bus.ex_ld_signed = 1'b0; bus.ex_ld_off = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    readaddr1 = '0; readaddr2 = '0;
    tick(); tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_waddr", {27'd0, writeaddr}, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_lerr", {31'd0, load_err}, 32'd0);
    chk("rst_ret", retired, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op rd=5 with bypass on port 1
    readaddr1 = 5'd5; readaddr2 = 5'd6;
    alu(5'd5, 32'hDEAD_BEEF);
    tick();
    bus.ex_valid = 1'b0;
    chk("alu_we", {31'd0, we}, 32'd1);
    chk("alu_waddr", {27'd0, writeaddr}, 32'd5);
    chk("alu_wdata", writedata, 32'hDEAD_BEEF);
    chk("alu_fwd1", {31'd0, fwd1}, 32'd1);
    chk("alu_fwd2", {31'd0, fwd2}, 32'd0);
    chk("alu_fwdd", fwd_data, 32'hDEAD_BEEF);
    chk("alu_ret", retired, 32'd1);
    tick();
    chk("alu_we_pulse", {31'd0, we}, 32'd0);
    chk("alu_fwd1_off", {31'd0, fwd1}, 32'd0);

    // back-to-back writes
    alu(5'd7, 32'd1);
    tick();
    chk("b2b_a_we", {31'd0, we}, 32'd1);
    chk("b2b_a_waddr", {27'd0, writeaddr}, 32'd7);
    alu(5'd8, 32'd2);
    tick();
    bus.ex_valid = 1'b0;
    chk("b2b_b_we", {31'd0, we}, 32'd1);
    chk("b2b_b_waddr", {27'd0, writeaddr}, 32'd8);
    chk("b2b_b_wdata", writedata, 32'd2);
    chk("b2b_ret", retired, 32'd3);
    tick();

    // load byte signed off=2, data 3 cycles later
    ld(5'd9, 2'd0, 1'b1, 2'd2);
    tick();
    bus.ex_valid = 1'b0;
    chk("lb_stall1", {31'd0, bus.stall}, 32'd1);
    chk("lb_we1", {31'd0, we}, 32'd0);
    tick();
    chk("lb_stall2", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("lb_stall3", {31'd0, bus.stall}, 32'd1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0080_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("lb_we", {31'd0, we}, 32'd1);
    chk("lb_waddr", {27'd0, writeaddr}, 32'd9);
    chk("lb_wdata", writedata, 32'hFFFF_FF80);
    chk("lb_stall_low", {31'd0, bus.stall}, 32'd0);
    chk("lb_ret", retired, 32'd4);
    tick();
    chk("lb_we_pulse", {31'd0, we}, 32'd0);

    // load half unsigned off=2, minimum latency
    ld(5'd10, 2'd1, 1'b0, 2'd2);
    tick();
    bus.ex_valid = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8001_1234;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("lhu_we", {31'd0, we}, 32'd1);
    chk("lhu_wdata", writedata, 32'h0000_8001);
    chk("lhu_ret", retired, 32'd5);
    tick();

    // load half signed off=0
    ld(5'd3, 2'd1, 1'b1, 2'd0);
    tick();
    bus.ex_valid = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_8001;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("lh_wdata", writedata, 32'hFFFF_8001);
    chk("lh_ret", retired, 32'd6);
    tick();

    // load timeout: 16 cycles without mem_rvalid
    ld(5'd11, 2'd2, 1'b0, 2'd0);
    tick();
    bus.ex_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_stall%0d", i), {30'd0, bus.stall, we}, 32'd2);
      tick();
    end
    chk("to_stall_low", {31'd0, bus.stall}, 32'd0);
    chk("to_lerr", {31'd0, load_err}, 32'd1);
    chk("to_we", {31'd0, we}, 32'd0);
    chk("to_ret", retired, 32'd6);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("to_late_we", {31'd0, we}, 32'd0);

    // rd=0 write
    readaddr1 = 5'd0;
    alu(5'd0, 32'd7);
    tick();
    bus.ex_valid = 1'b0;
    chk("r0_we", {31'd0, we}, 32'd0);
    chk("r0_fwd1", {31'd0, fwd1}, 32'd0);
    chk("r0_ret", retired, 32'd7);
    chk("r0_lerr_sticky", {31'd0, load_err}, 32'd1);

    // IO register write, never bypassed
    readaddr1 = 5'd30; readaddr2 = 5'd30;
    alu(5'd30, 32'h1234_5678);
    tick();
    bus.ex_valid = 1'b0;
    chk("io_we", {31'd0, we}, 32'd1);
    chk("io_waddr", {27'd0, writeaddr}, 32'd30);
    chk("io_fwd", {30'd0, fwd1, fwd2}, 32'd0);
    chk("io_ret", retired, 32'd8);

    // bypass on port 2 only
    readaddr1 = 5'd0; readaddr2 = 5'd12;
    alu(5'd12, 32'hCAFE_0001);
    tick();
    bus.ex_valid = 1'b0;
    chk("p2_fwd", {30'd0, fwd1, fwd2}, 32'd1);
    chk("p2_fwdd", fwd_data, 32'hCAFE_0001);
    tick();

    // reset during LOAD_WAIT, late mem_rvalid ignored
    ld(5'd13, 2'd2, 1'b0, 2'd0);
    tick();
    bus.ex_valid = 1'b0;
    chk("rl_stall", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABCD_EF01;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rl_we", {31'd0, we}, 32'd0);
    chk("rl_stall_low", {31'd0, bus.stall}, 32'd0);
    chk("rl_waddr", {27'd0, writeaddr}, 32'd0);
    chk("rl_wdata", writedata, 32'd0);
    chk("rl_lerr", {31'd0, load_err}, 32'd0);
    chk("rl_ret", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
